// File: rtl/button_counter_ctrl.sv
// Two-button LED counter controller: synchronized, debounced buttons drive a
// press-to-step / hold-to-autorepeat counter, with a clear button that has priority.

module btn_debounce #(
    parameter int unsigned CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic pressed_o
);
    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [1:0]       sync_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Raw level is active-low; flops reset to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            db_q   <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                db_d  = sync_q[1];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pressed_o = ~db_q;
endmodule

module button_counter_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_RATE     = 1200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       btn_n,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             clr_active
);
    localparam int unsigned TMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_t;

    logic [1:0]       pressed;
    logic             clr_pressed, inc_pressed;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             fire;

    for (genvar g = 0; g < 2; g++) begin : g_btn
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk       (clk),
            .rst       (rst),
            .btn_n_i   (btn_n[g]),
            .pressed_o (pressed[g])
        );
    end

    assign clr_pressed = pressed[0];
    assign inc_pressed = pressed[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        fire    = 1'b0;
        if (clr_pressed) begin
            state_d = IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inc_pressed) state_d = FIRST;
                end
                FIRST: begin
                    fire    = 1'b1;
                    tmr_d   = TMR_W'(REPEAT_DELAY - 1);
                    state_d = DELAY;
                end
                DELAY, REPEAT: begin
                    // Release wins over a timer expiry in the same cycle.
                    if (!inc_pressed) begin
                        state_d = IDLE;
                    end else if (tmr_q == '0) begin
                        fire    = 1'b1;
                        tmr_d   = TMR_W'(REPEAT_RATE - 1);
                        state_d = REPEAT;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        led_d = led_q;
        if (clr_pressed) led_d = '0;
        else if (fire)   led_d = led_q + 1'b1;
    end

    // Masking the output lets led read 0 in the very cycle clear is accepted.
    assign led        = clr_pressed ? '0 : led_q;
    assign step       = fire;
    assign clr_active = clr_pressed;
endmodule
